// File: rtl/bin2bcd_seq_if.sv
// ============================================================================
// Module   : bin2bcd_seq_if
// Purpose  : Handshake bundle for the sequential binary-to-BCD converter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface bin2bcd_seq_if #(
  parameter int W      = 18,
  parameter int DIGITS = 6
);
  localparam int c_ndw = $clog2(DIGITS + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic [c_ndw-1:0]      ndig;
  logic                  neg;
  logic                  busy;

  modport master (
    output in_valid, bin, out_ready,
    input  in_ready, out_valid, bcd, ndig, neg, busy
  );

  modport slave (
    input  in_valid, bin, out_ready,
    output in_ready, out_valid, bcd, ndig, neg, busy
  );
endinterface

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Double-dabble binary-to-BCD converter, one bit per clock.
//            Define BIN2BCD_SIGNED_EN for two's-complement input with sign.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq #(
  parameter int W      = 18,
  parameter int DIGITS = 6
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  bin2bcd_seq_if.slave   bus
);

  localparam int c_bw  = 4 * DIGITS;
  localparam int c_ndw = $clog2(DIGITS + 1);
  localparam int c_cw  = $clog2(W + 1);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_shift = 2'd1;
  localparam logic [1:0] c_done  = 2'd2;

  generate
    if (W < 2 || W > 32) begin : g_width_check
      $fatal(1, "bin2bcd_seq: W must be in 2..32");
    end
    if ((64'd10 ** DIGITS) < (64'd1 << W)) begin : g_size_check
      $fatal(1, "bin2bcd_seq: DIGITS too small to hold 2**W-1");
    end
  endgenerate

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [W-1:0]      r_op;
  logic [c_bw-1:0]   r_acc;
  logic [c_cw-1:0]   r_cnt;
  logic [c_bw-1:0]   r_bcd;
  logic [c_ndw-1:0]  r_ndig;
  logic [c_bw-2:0]   w_adj;
  logic [c_bw-1:0]   w_acc_next;
  logic [c_ndw-1:0]  w_ndig;
  logic [W-1:0]      w_operand;
  logic              w_accept;
  logic              w_last;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_busy;

  assign w_accept = (r_state == c_idle) && bus.in_valid;
  assign w_last   = (r_state == c_shift) && (r_cnt == c_cw'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (bus.in_valid) w_next = c_shift;
      c_shift: if (w_last)       w_next = c_done;
      c_done:  if (bus.out_ready) w_next = c_idle;
      default: w_next = c_idle;
    endcase
  end

  // Output decode
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      c_idle:  w_in_ready = 1'b1;
      c_shift: w_busy     = 1'b1;
      c_done:  begin
        w_out_valid = 1'b1;
        w_busy      = 1'b1;
      end
      default: w_in_ready = 1'b0;
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;

  // Add-3 adjust; the top digit's bit 3 is shifted out, so only its low bits are kept.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] w_d;
      assign w_d = r_acc[4*gi +: 4];
      if (gi == DIGITS - 1) begin : g_top
        assign w_adj[4*gi +: 3] = (w_d >= 4'd5) ? (w_d[2:0] + 3'd3) : w_d[2:0];
      end else begin : g_low
        assign w_adj[4*gi +: 4] = (w_d >= 4'd5) ? (w_d + 4'd3) : w_d;
      end
    end
  endgenerate

  assign w_acc_next = {w_adj, r_op[W-1]};

  always_comb begin
    w_ndig = c_ndw'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (w_acc_next[4*i +: 4] != 4'd0) begin
        w_ndig = c_ndw'(i + 1);
      end
    end
  end

`ifdef BIN2BCD_SIGNED_EN
  logic r_sign;
  logic r_neg;

  // Negating the most negative value wraps to 2**(W-1), which is correct as unsigned.
  assign w_operand = bus.bin[W-1] ? ((~bus.bin) + W'(1)) : bus.bin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
      r_neg  <= 1'b0;
    end else if (w_accept) begin
      r_sign <= bus.bin[W-1];
    end else if (w_last) begin
      r_neg  <= r_sign;
    end
  end

  assign bus.neg = r_neg;
`else
  assign w_operand = bus.bin;
  assign bus.neg   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_bcd  <= '0;
      r_ndig <= '0;
    end else if (w_accept) begin
      r_op  <= w_operand;
      r_acc <= '0;
      r_cnt <= c_cw'(W);
    end else if (r_state == c_shift) begin
      r_acc <= w_acc_next;
      r_op  <= {r_op[W-2:0], 1'b0};
      r_cnt <= r_cnt - c_cw'(1);
      if (w_last) begin
        r_bcd  <= w_acc_next;
        r_ndig <= w_ndig;
      end
    end
  end

  assign bus.bcd  = r_bcd;
  assign bus.ndig = r_ndig;

endmodule

`default_nettype wire

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.
- Replaces the wide combinational converter on display and UART-print paths where timing closure matters more than latency.
- valid/ready handshake on both sides.
- Also reports the significant digit count, used for leading-zero blanking on the 7-segment driver.

Parameters:
- W, 18, input binary width (2..32).
- DIGITS, 6, number of BCD output digits. Elaboration fails with $fatal if 10**DIGITS < 2**W.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  bin is valid
- in_ready  out  1  converter can accept; high only in IDLE
- bin  in  W  binary operand, sampled on the accept edge
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- bcd  out  4*DIGITS  {most significant digit,...,ones}, packed BCD
- ndig  out  $clog2(DIGITS+1)  count of significant digits, 1..DIGITS
- neg  out  1  sign of result; constant 0 unless the optional feature is enabled
- busy  out  1  high in SHIFT or DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - bcd=0, ndig=0, neg=0; internal shift register and counter cleared.
  - Applies immediately, including mid-conversion; any in-flight conversion is discarded with no partial result.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On in_valid=1, capture bin into operand register, clear BCD accumulator, load bit counter cnt=W, go to SHIFT.
  - SHIFT: each cycle:
    - First, every digit of the accumulator that is >=5 gets +3 (all DIGITS digits in parallel, 4-bit wrap-free since digit <=9 before adjust).
    - Then shift {accumulator, operand} left by 1, operand MSB entering accumulator bit 0.
    - Decrement cnt. When cnt reaches 0 after the shift, go to DONE.
  - DONE: out_valid=1. bcd, ndig and neg are registered outputs loaded on the edge entering DONE. On out_valid & out_ready, go to IDLE.
- Latency and throughput:
  - The accept edge is edge 0; out_valid first high after edge W (18 for the default).
  - If out_ready is held high, out_valid stays high for exactly one cycle.
  - Minimum period between accepts is W+2 cycles.
- Output hold: bcd/ndig/neg keep the last result after handoff until the next entry to DONE. They never show intermediate accumulator values.
- Backpressure: out_ready=0 in DONE holds the state and all outputs indefinitely; in_ready stays 0.
- Input stalls: in_valid while not in IDLE is ignored, and no value is queued. bin is don't-care outside the accept edge.
- ndig: 1 + index of the highest nonzero digit; zero input gives ndig=1.
- No overflow is possible at runtime; sizing is enforced by the DIGITS check.

Optional Feature:
- Macro: BIN2BCD_SIGNED_EN.
- Defined:
  - bin is two's complement.
  - On the accept edge, neg=bin[W-1] is latched and the operand is loaded with |bin| as a W-bit unsigned value, so -2**(W-1) maps correctly.
  - neg is presented with the result.
  - Zero gives neg=0.
  - Latency is unchanged.
- Undefined: bin is unsigned and neg is tied 0. No sign logic is generated.

Test Plan:
- Reset, then bin=0 accepted -> after 18 cycles out_valid=1, bcd=24'h000000, ndig=1, neg=0.
- bin=262143 (max, W=18) -> bcd=24'h262143, ndig=6, out_valid exactly 18 edges after the accept edge.
- bin=1000, out_ready=0 for 5 cycles -> bcd=24'h001000 and ndig=4 held stable, in_ready=0 throughout. Handoff on out_ready=1, then IDLE next cycle.
- Back-to-back: bin=9 then bin=10, with in_valid held high and out_ready=1 -> results 24'h000009 (ndig 1) and 24'h000010 (ndig 2). Accepts spaced W+2 cycles apart; in_valid during SHIFT is not captured.
- Reset mid-operation: accept 12345, pull rst_n low after 9 shifts -> all outputs 0 immediately. Release, accept 42 -> bcd=24'h000042, ndig=2.
- BIN2BCD_SIGNED_EN, W=18:
  - bin=18'h20000 -> neg=1, bcd=24'h131072.
  - bin=18'h3FFFF -> neg=1, bcd=24'h000001.
  - bin=5 -> neg=0, bcd=24'h000005.
